// File: rtl/ps2_key_controller.sv
// Scan-code sequencer: resolves E0/F0/E1 prefixes into make/break events and a held-key bitmap.
// Latency: one cycle from the final byte's strobe to key_event (all outputs registered).
// No back-pressure: a byte may arrive every cycle; a stalled prefix is dropped by a watchdog.
module ps2_key_controller #(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int CNT_W          = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       key_event,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_make,
  output logic [5:0] keys_held,
  output logic       seq_err
);

  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, PAUSE} state_t;

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [2:0]       skip, skip_n;
  logic [CNT_W-1:0] wd_cnt;
  logic             wd_expire;
  logic             ev_n, ext_n, make_n, err_n, clr_n;
  logic [7:0]       code_n;
  logic [5:0]       held_n;

  // Watchdog only matters while a multi-byte sequence is open.
  assign wd_expire = (state != IDLE) && (wd_cnt == WD_LAST);

  // Next-state and event decode; a real byte always takes priority over expiry.
  always_comb begin
    state_n = state;
    skip_n  = skip;
    ev_n    = 1'b0;
    code_n  = byte_data;
    ext_n   = 1'b0;
    make_n  = 1'b1;
    err_n   = 1'b0;
    clr_n   = 1'b0;
    if (byte_valid) begin
      case (state)
        IDLE: begin
          case (byte_data)
            8'hE0: state_n = EXT;
            8'hF0: state_n = BRK;
            8'hE1: begin
              state_n = PAUSE;
              skip_n  = 3'd7;
            end
            8'hFA, 8'hAA, 8'hEE, 8'hFE: ;
            8'h00, 8'hFF: begin
              err_n = 1'b1;
              clr_n = 1'b1;
            end
            default: ev_n = 1'b1;
          endcase
        end
        EXT: begin
          case (byte_data)
            8'hF0: state_n = EXT_BRK;
            8'hE0: state_n = EXT;
            default: begin
              ev_n    = 1'b1;
              ext_n   = 1'b1;
              state_n = IDLE;
            end
          endcase
        end
        BRK, EXT_BRK: begin
          state_n = IDLE;
          if (byte_data == 8'hE0 || byte_data == 8'hF0) begin
            err_n = 1'b1;
          end else begin
            ev_n   = 1'b1;
            make_n = 1'b0;
            ext_n  = (state == EXT_BRK);
          end
        end
        PAUSE: begin
          skip_n = skip - 3'd1;
          if (skip == 3'd1) begin
            ev_n    = 1'b1;
            code_n  = 8'h77;
            ext_n   = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (wd_expire) begin
      err_n   = 1'b1;
      state_n = IDLE;
    end
  end

  // Bitmap update: only the six mapped (ext, code) pairs touch their bit.
  always_comb begin
    held_n = keys_held;
    if (clr_n) begin
      held_n = 6'd0;
    end else if (ev_n) begin
      case ({ext_n, code_n})
        9'h01D:  held_n[0] = make_n;
        9'h01B:  held_n[1] = make_n;
        9'h175:  held_n[2] = make_n;
        9'h172:  held_n[3] = make_n;
        9'h029:  held_n[4] = make_n;
        9'h076:  held_n[5] = make_n;
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      skip      <= 3'd0;
      wd_cnt    <= '0;
      key_event <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_make  <= 1'b0;
      keys_held <= 6'd0;
      seq_err   <= 1'b0;
    end else begin
      state     <= state_n;
      skip      <= skip_n;
      wd_cnt    <= (byte_valid || state_n == IDLE) ? '0 : wd_cnt + 1'b1;
      key_event <= ev_n;
      seq_err   <= err_n;
      keys_held <= held_n;
      if (ev_n) begin
        key_code <= code_n;
        key_ext  <= ext_n;
        key_make <= make_n;
      end
    end
  end

endmodule

// File: doc/ps2_key_controller.md
# ps2_key_controller

Scan-code sequencer between the PS/2 byte receiver and the game logic. It consumes the Set-2 byte stream one byte at a time and resolves the E0 (extended), F0 (break) and E1 (pause) prefixes. It emits one make/break event per complete key sequence and maintains a held-key bitmap for the six game keys. A prefix watchdog returns the parser to idle if a multi-byte sequence stalls.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2_500_000: maximum clk cycles allowed between bytes inside a prefix sequence (50 ms at 50 MHz); minimum legal value 2.
- `CNT_W`, default 22: width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- `clk`  in  1: system clock, single clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `byte_valid`  in  1: one-cycle strobe, `byte_data` is a new received scan byte.
- `byte_data`  in  8: received scan byte.
- `key_event`  out  1: one-cycle strobe, a complete key sequence was decoded.
- `key_code`  out  8: final scan code of the event; held until the next event.
- `key_ext`  out  1: event was E0-prefixed.
- `key_make`  out  1: 1 = press, 0 = release.
- `keys_held`  out  6: level bitmap. Bit 0 is W (1D), bit 1 S (1B), bit 2 Up (E0 75), bit 3 Down (E0 72), bit 4 Space (29), bit 5 Esc (76).
- `seq_err`  out  1: one-cycle strobe on watchdog timeout or keyboard error byte (00/FF).

## Operation
- FSM states:
  - IDLE.
  - EXT: E0 seen.
  - BRK: F0 seen.
  - EXT_BRK: E0 F0 seen.
  - PAUSE: swallowing the E1 sequence.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1 -> PAUSE with skip counter = 7.
  - FA, AA, EE, FE: ignored, no event.
  - 00 or FF: `seq_err` pulse, `keys_held` cleared, stay IDLE.
  - Any other byte: make event (ext=0), stay IDLE.
- EXT transitions:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT.
  - Any other byte: make event (ext=1) -> IDLE.
- BRK: any byte except E0/F0 gives a break event (ext=0) -> IDLE. E0 or F0 in BRK or EXT_BRK is a protocol violation: `seq_err`, -> IDLE, byte discarded.
- EXT_BRK: any byte gives a break event (ext=1) -> IDLE, except E0/F0 as above.
- PAUSE: each byte decrements the skip counter. The byte that takes it to 0 emits one make event, code 0x77, ext=1, and returns to IDLE. There is no pause break event.
- Bitmap: a make event for a mapped (code, ext) pair sets its bit; the matching break clears it. Unmapped codes change nothing. Non-extended 75/72 (keypad) never touch bits 2/3.
- Watchdog:
  - Counter is cleared on every `byte_valid` and held at 0 in IDLE.
  - Otherwise it increments each cycle.
  - On reaching TIMEOUT_CYCLES-1: `seq_err` pulse, FSM -> IDLE, `keys_held` unchanged.
- `byte_valid` and watchdog expiry in the same cycle: the byte is processed, the timeout is discarded.
- `byte_valid` asserted on consecutive cycles: every byte is processed, no back-pressure.

## Timing
- Reset values: `key_event`=0, `key_code`=00, `key_ext`=0, `key_make`=0, `keys_held`=000000, `seq_err`=0. FSM=IDLE, counters=0.
- `rst` wins over `byte_valid` in the same cycle.
- Reset mid-sequence discards the partial prefix.
- Latency: the final byte's `byte_valid` at edge N gives `key_event` high for exactly the cycle after edge N. `key_code`/`key_ext`/`key_make` and the updated `keys_held` are valid in that same cycle.
- `key_event` and `seq_err` are never high for more than one consecutive cycle per cause. They are mutually exclusive in a cycle.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last byte in a non-IDLE state.

## Test plan
- Bytes 1D, F0 1D -> event {1D, ext0, make1}, `keys_held`=000001. Then event {1D, ext0, make0}, `keys_held`=000000. Each event is 1 cycle after the last byte.
- Bytes E0 75, 75, E0 F0 75 -> `keys_held[2]`=1. The keypad 75 event has ext=0 and leaves the bitmap at 000100. The final break clears bit 2.
- Pause sequence E1 14 77 E1 F0 14 F0 77 -> exactly one event {77, ext1, make1}. No event for the intermediate 14/77 bytes; FSM ends in IDLE.
- TIMEOUT_CYCLES=16, byte E0 then silence -> `seq_err` 16 cycles later, no event. A following 29 gives event {29, ext0, make1}, not ext1.
- With W and Space held, byte FF -> `seq_err`, `keys_held`=000000. Bytes FA, AA -> no events.
- `rst` asserted between F0 and 1B -> no event. A subsequent 1B is decoded as a make (`keys_held[1]`=1), and all outputs read reset values during reset.
